// File: rtl/camera_decoder_pkg.sv
// -----------------------------------------------------------------------------
// camera_decoder_pkg
// Types and constants shared by the camera decoder schedulers.
//   ctx_e            : syntax contexts the shared symbol mapper recognises
//   CTX_MAX_DEFINED  : highest defined context; anything above it takes the
//                      mapper's default path
//   out_state_e      : occupancy of a single-entry result register
//   sat_inc16        : saturating 16-bit increment for event counters
// -----------------------------------------------------------------------------
package camera_decoder_pkg;

  typedef enum logic [1:0] {
    CTX_QP     = 2'd0,
    CTX_MV     = 2'd1,
    CTX_FLAG   = 2'd2,
    CTX_CUSTOM = 2'd3
  } ctx_e;

  localparam int CTX_MAX_DEFINED = 3;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/rr_arbiter_onehot.sv
// -----------------------------------------------------------------------------
// rr_arbiter_onehot
// Purely combinational round-robin pick: the first requester at or after
// i_ptr, wrapping modulo N.
//   i_req   [N]   request vector
//   i_ptr   [IW]  lane with highest priority this cycle (must be < N)
//   i_en    [1]   when low, no grant is issued
//   o_grant [N]   one-hot grant, or zero
//   o_idx   [IW]  encoded index of the grant (0 when no grant)
// -----------------------------------------------------------------------------
module rr_arbiter_onehot #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  input  logic          i_en,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_idx
);

  logic w_found;
  int   w_lane;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    o_grant = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_lane  = 0;
    for (int k = 0; k < N; k++) begin
      w_lane = (int'(i_ptr) + k) % N;
      if (i_en && !w_found && i_req[w_lane]) begin
        w_found         = 1'b1;
        o_grant[w_lane] = 1'b1;
        o_idx           = IW'(w_lane);
      end
    end
  end

endmodule

// File: rtl/symbol_map_arbiter.sv
// -----------------------------------------------------------------------------
// symbol_map_arbiter
// Shares one combinational symbol mapper between NUM_REQ ANS decoder lanes.
// The round-robin winner's symbol/context is driven onto map_*, the mapper's
// answer is captured with the lane ID into a single-entry output register and
// offered downstream with valid/ready.
//   clk, rst_n                 clock, asynchronous active-low reset
//   enable                     gate for new grants (held output still drains)
//   req_valid/ready            per-lane handshake, ready is one-hot or zero
//   req_symbol/req_context     packed per-lane payloads
//   map_symbol/map_context     to the shared mapper (0 when nothing granted)
//   map_syntax                 mapper result, same cycle
//   out_valid/ready/syntax/id  registered result towards the consumer
//   default_hits               saturating count of accepts with context > 3
// -----------------------------------------------------------------------------
module symbol_map_arbiter
  import camera_decoder_pkg::*;
#(
  parameter  int NUM_REQ       = 4,
  parameter  int SYMBOL_WIDTH  = 4,
  parameter  int CONTEXT_WIDTH = 4,
  parameter  int SYNTAX_WIDTH  = 16,
  localparam int ID_W          = $clog2(NUM_REQ)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             enable,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [NUM_REQ*SYMBOL_WIDTH-1:0]  req_symbol,
  input  logic [NUM_REQ*CONTEXT_WIDTH-1:0] req_context,
  output logic [SYMBOL_WIDTH-1:0]          map_symbol,
  output logic [CONTEXT_WIDTH-1:0]         map_context,
  input  logic [SYNTAX_WIDTH-1:0]          map_syntax,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [SYNTAX_WIDTH-1:0]          out_syntax,
  output logic [ID_W-1:0]                  out_id,
  output logic [15:0]                      default_hits
);

  out_state_e              r_state;
  out_state_e              w_state_next;
  logic [ID_W-1:0]         r_ptr;
  logic [SYNTAX_WIDTH-1:0] r_out_syntax;
  logic [ID_W-1:0]         r_out_id;
  logic [15:0]             r_default_hits;

  logic [NUM_REQ-1:0]      w_grant;
  logic [ID_W-1:0]         w_idx;
  logic                    w_can_accept;
  logic                    w_accept;
  logic                    w_default_hit;
  logic [ID_W-1:0]         w_ptr_next;

  // rst_n is folded in so no lane sees ready while the block is held in reset.
  assign w_can_accept = rst_n && enable && (!out_valid || out_ready);

  rr_arbiter_onehot #(.N(NUM_REQ)) u_rr (
    .i_req   (req_valid),
    .i_ptr   (r_ptr),
    .i_en    (w_can_accept),
    .o_grant (w_grant),
    .o_idx   (w_idx)
  );

  assign req_ready     = w_grant;
  assign w_accept      = |w_grant;
  assign w_default_hit = w_accept && (int'(map_context) > CTX_MAX_DEFINED);
  assign w_ptr_next    = (int'(w_idx) == NUM_REQ - 1) ? '0 : w_idx + ID_W'(1);

  // Granted lane's payload to the shared mapper; idle mapper inputs stay 0.
  always_comb begin
    map_symbol  = '0;
    map_context = '0;
    if (w_accept) begin
      map_symbol  = req_symbol[int'(w_idx)*SYMBOL_WIDTH +: SYMBOL_WIDTH];
      map_context = req_context[int'(w_idx)*CONTEXT_WIDTH +: CONTEXT_WIDTH];
    end
  end

  // Output-register occupancy FSM: state register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!rst_n) r_state <= ST_EMPTY;
    else        r_state <= w_state_next;
  end

  // Next state: a new accept always fills; otherwise a full entry empties
  // only when downstream takes it.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_EMPTY: if (w_accept) w_state_next = ST_FULL;
      ST_FULL:  if (!w_accept && out_ready) w_state_next = ST_EMPTY;
      default:  w_state_next = ST_EMPTY;
    endcase
  end

  // Outputs of the FSM.
  always_comb begin
    out_valid = (r_state == ST_FULL);
  end

  // Result payload, pointer and statistics.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_syntax   <= '0;
      r_out_id       <= '0;
      r_ptr          <= '0;
      r_default_hits <= '0;
    end else if (w_accept) begin
      r_out_syntax <= map_syntax;
      r_out_id     <= w_idx;
      r_ptr        <= w_ptr_next;
      if (w_default_hit) r_default_hits <= sat_inc16(r_default_hits);
    end
  end

  assign out_syntax   = r_out_syntax;
  assign out_id       = r_out_id;
  assign default_hits = r_default_hits;

endmodule
